// File: rtl/mac_accum_pkg.sv
// Shared types and helpers for the MAC accumulate stage.
// Latency: n/a (types, defaults and pure functions only).
// Backpressure: n/a.
package mac_accum_pkg;

  typedef enum logic [1:0] {
    SEL_0 = 2'd0,
    SEL_1 = 2'd1,
    SEL_2 = 2'd2,
    SEL_3 = 2'd3
  } sel_t;

  localparam int SW_DEF = 8;
  localparam int CW_DEF = 8;
  localparam int OW_DEF = 16;

  // Clamp a sign-extended value into the signed range of an ow-bit result.
  function automatic logic signed [63:0] sat_conv(input logic signed [63:0] v, input int ow);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (ow - 1));
    if (v > max_v) begin
      return max_v;
    end else if (v < min_v) begin
      return min_v;
    end
    return v;
  endfunction

  // True when a sign-extended value does not fit a signed ow-bit result.
  function automatic logic out_of_range(input logic signed [63:0] v, input int ow);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (ow - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (ow - 1));
    return (v > max_v) || (v < min_v);
  endfunction

endpackage

// File: rtl/mac_accum_stage_term.sv
// Lane select and signed multiply for one MAC term.
// Latency: combinational.
// Backpressure: none, evaluated every cycle.
module mac_term
  import mac_accum_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic [4*SW-1:0]         sample_in,
  input  logic [4*CW-1:0]         coef_in,
  input  sel_t                    sel,
  output logic signed [SW+CW-1:0] term
);

  logic signed [SW-1:0] samp;
  logic signed [CW-1:0] coef;

  // Pick the selected lane and form the full-width signed product.
  always_comb begin
    samp = $signed(sample_in[int'(sel)*SW +: SW]);
    coef = $signed(coef_in[int'(sel)*CW +: CW]);
    term = (SW+CW)'(samp) * (SW+CW)'(coef);
  end

endmodule

// File: rtl/mac_accum_stage.sv
// Accumulates one 4-phase frame of sample*coef terms and hands the sum downstream.
// Latency: result valid 1 clk after the strobe cycle; clear restarts the frame after that cycle.
// Backpressure: valid/ready output; a strobe while full and not ready is dropped (overrun).
// Build option: define SATURATE_EN to clamp results, otherwise results wrap to OW bits.
module mac_accum_stage
  import mac_accum_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int CW = CW_DEF,
  parameter int OW = OW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4*SW-1:0] sample_in,
  input  logic [4*CW-1:0] coef_in,
  input  logic [1:0]      mux_control,
  input  logic            clear_accum,
  input  logic            data_strobe,
  input  logic            out_ready,
  output logic [OW-1:0]   result,
  output logic            result_valid,
  output logic            clipped,
  output logic            overrun,
  output logic            seq_error
);

  // Two guard bits: four full-width products cannot overflow the accumulator.
  localparam int AW = SW + CW + 2;

  logic signed [SW+CW-1:0] term;
  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [OW-1:0]           sum_conv;
  logic                    sum_clip;
  logic                    load;
  logic                    xfer;
  logic [OW-1:0]           result_q, result_d;
  logic                    result_valid_q, result_valid_d;
  logic                    clipped_q, clipped_d;
  logic                    overrun_q, overrun_d;
  logic                    seq_error_q, seq_error_d;
  sel_t                    exp_sel_q, exp_sel_d;

  mac_term #(
    .SW(SW),
    .CW(CW)
  ) u_term (
    .sample_in(sample_in),
    .coef_in  (coef_in),
    .sel      (sel_t'(mux_control)),
    .term     (term)
  );

  // Running sum including this cycle's term; the clear cycle's term still closes the old frame.
  always_comb begin
    sum      = acc_q + AW'(term);
    acc_d    = clear_accum ? '0 : sum;
    sum_clip = out_of_range(64'(sum), OW);
`ifdef SATURATE_EN
    sum_conv = OW'(sat_conv(64'(sum), OW));
`else
    sum_conv = OW'(sum);
`endif
  end

  // Output register: load on strobe when there is room, drop and flag when full and stalled.
  always_comb begin
    load           = data_strobe && (!result_valid_q || out_ready);
    xfer           = result_valid_q && out_ready;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    clipped_d      = clipped_q;
    if (load) begin
      result_d       = sum_conv;
      clipped_d      = sum_clip;
      result_valid_d = 1'b1;
    end else if (xfer) begin
      result_valid_d = 1'b0;
    end
    overrun_d = overrun_q | (data_strobe && result_valid_q && !out_ready);
  end

  // Sequence checker: expects 0,1,2,3 order and the strobe only on the last phase;
  // expectation follows the observed select so one glitch does not cascade.
  always_comb begin
    seq_error_d = seq_error_q;
    if ((mux_control != exp_sel_q) || (data_strobe && (mux_control != SEL_3))) begin
      seq_error_d = 1'b1;
    end
    exp_sel_d = sel_t'(mux_control + 2'd1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      clipped_q      <= 1'b0;
      overrun_q      <= 1'b0;
      seq_error_q    <= 1'b0;
      exp_sel_q      <= SEL_0;
    end else begin
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      clipped_q      <= clipped_d;
      overrun_q      <= overrun_d;
      seq_error_q    <= seq_error_d;
      exp_sel_q      <= exp_sel_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign clipped      = clipped_q;
  assign overrun      = overrun_q;
  assign seq_error    = seq_error_q;

endmodule

// File: tb/tb_mac_accum_stage.sv
// Bench for mac_accum_stage: frame-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized frames.
// Honours SATURATE_EN the same way the design does.
module tb_mac_accum_stage;

  logic        clk;
  logic        reset;
  logic [31:0] sample_in;
  logic [31:0] coef_in;
  logic [1:0]  mux_control;
  logic        clear_accum;
  logic        data_strobe;
  logic        out_ready;
  logic [15:0] result;
  logic        result_valid;
  logic        clipped;
  logic        overrun;
  logic        seq_error;

  int n_checks = 0;
  int n_fail   = 0;

  mac_accum_stage #(.SW(8), .CW(8), .OW(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .coef_in     (coef_in),
    .mux_control (mux_control),
    .clear_accum (clear_accum),
    .data_strobe (data_strobe),
    .out_ready   (out_ready),
    .result      (result),
    .result_valid(result_valid),
    .clipped     (clipped),
    .overrun     (overrun),
    .seq_error   (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the frame is a list of products; outputs follow the handshake rules.
  int          m_terms[$];
  logic [15:0] m_result;
  bit          m_valid, m_clip, m_ovr, m_seq;
  int          m_exp;

  function automatic int lane(input logic [31:0] v, input int k);
    logic [7:0] b;
    b = v[k*8 +: 8];
    return int'($signed(b));
  endfunction

  function automatic logic [15:0] conv(input int s);
    logic [31:0] tmp;
`ifdef SATURATE_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    tmp = s;
    return tmp[15:0];
  endfunction

  task automatic model_step();
    int sel, t, s;
    if (reset) begin
      m_terms.delete();
      m_result = '0;
      m_valid  = 0;
      m_clip   = 0;
      m_ovr    = 0;
      m_seq    = 0;
      m_exp    = 0;
    end else begin
      sel = int'(mux_control);
      t   = lane(sample_in, sel) * lane(coef_in, sel);
      s   = t;
      foreach (m_terms[i]) s += m_terms[i];
      if (sel != m_exp) m_seq = 1;
      if (data_strobe && sel != 3) m_seq = 1;
      m_exp = (sel + 1) % 4;
      if (data_strobe) begin
        if (m_valid && !out_ready) begin
          m_ovr = 1;
        end else begin
          m_valid  = 1;
          m_result = conv(s);
          m_clip   = (s > 32767) || (s < -32768);
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      if (clear_accum) m_terms.delete();
      else m_terms.push_back(t);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Compare process: model advances on each rising edge, outputs checked on the falling edge.
  always begin
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("cyc_result",       32'(result),       32'(m_result));
    check("cyc_result_valid", 32'(result_valid), 32'(m_valid));
    check("cyc_clipped",      32'(clipped),      32'(m_clip));
    check("cyc_overrun",      32'(overrun),      32'(m_ovr));
    check("cyc_seq_error",    32'(seq_error),    32'(m_seq));
  end

  // Apply one cycle of inputs at a falling edge and return at the next falling edge.
  task automatic drive(input logic [31:0] s, input logic [31:0] c, input int sel,
                       input bit clr, input bit stb, input bit rdy, input bit rst);
    sample_in   = s;
    coef_in     = c;
    mux_control = 2'(sel);
    clear_accum = clr;
    data_strobe = stb;
    out_ready   = rdy;
    reset       = rst;
    @(negedge clk);
  endtask

  task automatic frame(input logic [31:0] s, input logic [31:0] c, input bit rdy_mid, input bit rdy_last);
    for (int p = 0; p < 4; p++) begin
      drive(s, c, p, p == 3, p == 3, (p == 3) ? rdy_last : rdy_mid, 1'b0);
    end
  endtask

  localparam logic [31:0] S1234  = 32'h04030201;
  localparam logic [31:0] ONES   = 32'h01010101;
  localparam logic [31:0] TWOS   = 32'h02020202;
  localparam logic [31:0] THREES = 32'h03030303;
  localparam logic [31:0] NEG128 = 32'h80808080;

  initial begin
    int sel;
    bit last, stb, clr, rst;
    reset       = 1'b1;
    sample_in   = '0;
    coef_in     = '0;
    mux_control = '0;
    clear_accum = 1'b0;
    data_strobe = 1'b0;
    out_ready   = 1'b0;
    @(negedge clk);
    check("rst_result",       32'(result),       32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_seq_error",    32'(seq_error),    32'd0);

    // Basic frame, then a back-to-back result while still valid.
    frame(S1234, ONES, 1'b1, 1'b1);
    check("t1_result", 32'(result),       32'd10);
    check("t1_valid",  32'(result_valid), 32'd1);
    check("t1_clip",   32'(clipped),      32'd0);
    frame(S1234, TWOS, 1'b0, 1'b1);
    check("t4_result",  32'(result),       32'd20);
    check("t4_valid",   32'(result_valid), 32'd1);
    check("t4_overrun", 32'(overrun),      32'd0);

    // Extreme products: 4 * 16384 = 65536.
    drive('0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(NEG128, NEG128, 1'b1, 1'b1);
`ifdef SATURATE_EN
    check("t2_result", 32'(result), 32'd32767);
`else
    check("t2_result", 32'(result), 32'd0);
`endif
    check("t2_clip", 32'(clipped), 32'd1);

    // Stalled output across two frames, then drain.
    drive('0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(S1234, ONES, 1'b0, 1'b0);
    frame(S1234, TWOS, 1'b0, 1'b0);
    check("t3_result_held", 32'(result),       32'd10);
    check("t3_overrun",     32'(overrun),      32'd1);
    check("t3_valid_held",  32'(result_valid), 32'd1);
    drive(S1234, THREES, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_valid_drop", 32'(result_valid), 32'd0);
    drive(S1234, THREES, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(S1234, THREES, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(S1234, THREES, 3, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t3_new_result", 32'(result), 32'd30);

    // Out-of-order select 0,1,3 then resync.
    drive('0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(S1234, ONES, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(S1234, ONES, 1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_seq_ok", 32'(seq_error), 32'd0);
    drive(S1234, ONES, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_seq_err", 32'(seq_error), 32'd1);
    drive(S1234, ONES, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_seq_sticky", 32'(seq_error), 32'd1);
    frame(S1234, ONES, 1'b1, 1'b1);

    // Reset mid-frame then a fresh frame.
    drive(S1234, ONES, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(S1234, ONES, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(S1234, ONES, 2, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_result",  32'(result),       32'd0);
    check("t6_valid",   32'(result_valid), 32'd0);
    check("t6_seq",     32'(seq_error),    32'd0);
    check("t6_overrun", 32'(overrun),      32'd0);
    frame(ONES, TWOS, 1'b1, 1'b1);
    check("t6_fresh", 32'(result), 32'd8);

    // Randomized frames: mostly well-formed, with occasional glitches and resets.
    for (int f = 0; f < 400; f++) begin
      for (int p = 0; p < 4; p++) begin
        sel = p;
        if ($urandom_range(0, 39) == 0) sel = int'($urandom_range(0, 3));
        last = (p == 3);
        stb  = last ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
        clr  = last ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0);
        rst  = ($urandom_range(0, 99) == 0);
        drive($urandom, $urandom, sel, clr, stb, 1'($urandom_range(0, 1)), rst);
      end
    end

    drive('0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
